exec_mult_unit: RTL and testbench
=================================

EXEC_MULT_UNIT -- requirements
Module: exec_mult_unit

Interface
REQ-001 Parameter: N_STAGES, default 4, number of pipeline register stages from issue to CDB output.
REQ-002 Ports, one per line (name  direction  width  meaning):
- clk  input  1  single clock; all state updates on its rising edge.
- reset  input  1  synchronous, active-high reset.
- issuemult_rdtag  input  6  destination tag of the offered instruction.
- issuemult_rsdata  input  32  first operand.
- issuemult_rtdata  input  32  second operand.
- issuemult_ready  input  1  the multiply queue offers a ready instruction this cycle.
- issuemult_done  output  1  the offered instruction is accepted this cycle.
- multcdb_req  output  1  a completed result is presented to the CDB arbiter.
- multcdb_tag  output  6  tag of the presented result.
- multcdb_data  output  32  presented result.
- multcdb_grant  input  1  the CDB arbiter takes the presented result this cycle.
REQ-003 The single clock is clk; reset is synchronous and active-high.

Function
REQ-004 The block SHALL be an in-order pipeline of N_STAGES slots, S1..SN. Each slot SHALL hold valid, tag[5:0] and data[31:0]. SN is the output slot.
REQ-005 The block SHALL produce the low 32 bits of rsdata*rtdata. Signed and unsigned multiply give the same low half; no overflow flag is produced.
REQ-006 The multiply work can be split across the stages in any way. Only the final SN data value is architecturally visible.
REQ-007 SN SHALL advance (leave the pipe) in a cycle when valid(SN) & multcdb_grant.
REQ-008 Sk, for k<N, SHALL advance into Sk+1 when valid(Sk) and (Sk+1 is empty or Sk+1 advances in the same cycle). This collapses bubbles.
REQ-009 A slot that does not advance and is not written SHALL keep its contents unchanged.
REQ-010 issuemult_done SHALL equal issuemult_ready & (S1 empty | S1 advances), combinationally in the same cycle. It SHALL be 0 during reset.
REQ-011 When issuemult_done=1, S1 SHALL capture the tag and operands at that clock edge.
REQ-012 Latency: an instruction accepted in cycle t SHALL appear with multcdb_req=1 in cycle t+N_STAGES when there are no stalls.
- Sustained throughput SHALL be one instruction per cycle while multcdb_grant=1.
REQ-013 multcdb_req SHALL equal valid(SN). multcdb_tag and multcdb_data SHALL equal SN contents. They SHALL stay stable while req=1 and grant=0.
REQ-014 multcdb_grant while multcdb_req=0 SHALL be ignored.
REQ-015 Full condition: all slots valid and grant=0. issuemult_done SHALL then be 0, and no instruction is lost or duplicated.
REQ-016 Simultaneous accept and drain when full: if grant=1, the whole pipe SHALL shift and S1 SHALL accept in the same cycle.
REQ-017 Results SHALL leave in issue order. Tags are passed through unmodified.

Reset
REQ-018 On a rising edge with reset=1, every slot valid bit SHALL clear to 0. Tag and data SHALL clear to 0.
REQ-019 Outputs during and after reset until the first accept: issuemult_done=0, multcdb_req=0, multcdb_tag=0, multcdb_data=0.
REQ-020 Reset mid-operation SHALL discard all in-flight instructions. No result from before the reset SHALL ever be presented.

Structure
REQ-021 TAG_W=6, DATA_W=32 and the default multiplier latency SHALL be shared constants in the common cobalt definitions package/header. The issue queue and CDB arbiter SHALL use the same constants.
REQ-022 One sub-module is natural: mult_pipe_slot, a valid/tag/data register with load, hold and synchronous clear. It is instantiated N_STAGES times.
- The advance/accept logic SHALL stay in exec_mult_unit.

Verification
REQ-023 The bench SHALL cover these directed scenarios, with grant held at 1 unless stated:
- Single multiply: ready=1 for one cycle with tag 7, rs=3, rt=5 -> done=1 that cycle; req=1 exactly 4 cycles later with tag 7, data 15, for one cycle.
- Back-to-back: four instructions on consecutive cycles, tags 1..4, operands (2,3), (4,5), (6,7), (8,9) -> req high on four consecutive cycles with data 6, 20, 42, 72 in tag order.
- Backpressure: grant=0 with ready held -> exactly 4 accepted; done=0 from the 5th cycle on; the output holds tag and data stable. Then grant=1 -> drains in order, and a new accept occurs in the same cycle as the first drain.
- Arithmetic edges:
  - 0xFFFFFFFF*2 -> 0xFFFFFFFE.
  - 0x00010000*0x00010000 -> 0x00000000.
  - 0x80000000*0xFFFFFFFF -> 0x80000000.
- Reset mid-flight: three instructions in flight, reset=1 for one cycle -> req=0 from the next cycle. None of the three tags ever appears.
- Idle and stray grant: ready=0 with grant toggling -> done=0 and req=0 throughout, and the pipe stays empty.

Source files
------------

// File: rtl/cobalt_pkg.sv
// cobalt_pkg: shared tag/data widths and default multiplier latency
package cobalt_pkg;
    localparam int TAG_W        = 6;
    localparam int DATA_W       = 32;
    localparam int MULT_LATENCY = 4;
endpackage

// File: rtl/mult_pipe_slot.sv
// mult_pipe_slot: one valid/tag/data pipeline register with load, hold and clear
module mult_pipe_slot
    import cobalt_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              load,
    input  logic              clear,
    input  logic [TAG_W-1:0]  d_tag,
    input  logic [DATA_W-1:0] d_data,
    output logic              q_valid,
    output logic [TAG_W-1:0]  q_tag,
    output logic [DATA_W-1:0] q_data
);
    // load wins over clear so a slot can drain and refill in the same cycle
    always_ff @(posedge clk) begin
        if (reset) begin
            q_valid <= 1'b0;
            q_tag   <= '0;
            q_data  <= '0;
        end else if (load) begin
            q_valid <= 1'b1;
            q_tag   <= d_tag;
            q_data  <= d_data;
        end else if (clear) begin
            q_valid <= 1'b0;
        end
    end
endmodule

// File: rtl/exec_mult_unit.sv
// exec_mult_unit: in-order bubble-collapsing multiply pipeline feeding the CDB
module exec_mult_unit
    import cobalt_pkg::*;
#(
    parameter int N_STAGES = MULT_LATENCY
)
(
    input  logic              clk,
    input  logic              reset,
    input  logic [TAG_W-1:0]  issuemult_rdtag,
    input  logic [DATA_W-1:0] issuemult_rsdata,
    input  logic [DATA_W-1:0] issuemult_rtdata,
    input  logic              issuemult_ready,
    output logic              issuemult_done,
    output logic              multcdb_req,
    output logic [TAG_W-1:0]  multcdb_tag,
    output logic [DATA_W-1:0] multcdb_data,
    input  logic              multcdb_grant
);
    logic [N_STAGES-1:0] vld, adv, load;
    logic [TAG_W-1:0]    tag_q  [N_STAGES];
    logic [DATA_W-1:0]   data_q [N_STAGES];
    logic [TAG_W-1:0]    in_tag [N_STAGES];
    logic [DATA_W-1:0]   in_data[N_STAGES];
    logic [DATA_W-1:0]   product;

    assign product        = issuemult_rsdata * issuemult_rtdata;
    assign issuemult_done = issuemult_ready & ~reset & (~vld[0] | adv[0]);
    assign multcdb_req    = vld[N_STAGES-1];
    assign multcdb_tag    = tag_q[N_STAGES-1];
    assign multcdb_data   = data_q[N_STAGES-1];

    // advance chain from the output slot backwards; a slot moves if the next one is empty or moving
    always_comb begin
        adv = '0;
        adv[N_STAGES-1] = vld[N_STAGES-1] & multcdb_grant;
        for (int i = N_STAGES - 2; i >= 0; i--)
            adv[i] = vld[i] & (~vld[i+1] | adv[i+1]);
    end

    // each slot loads from its predecessor when that one advances; S1 loads the finished product
    always_comb begin
        load       = '0;
        load[0]    = issuemult_done;
        in_tag[0]  = issuemult_rdtag;
        in_data[0] = product;
        for (int i = 1; i < N_STAGES; i++) begin
            load[i]    = adv[i-1];
            in_tag[i]  = tag_q[i-1];
            in_data[i] = data_q[i-1];
        end
    end

    genvar k;
    generate
        for (k = 0; k < N_STAGES; k++) begin : g_slot
            mult_pipe_slot u_slot (
                .clk     (clk),
                .reset   (reset),
                .load    (load[k]),
                .clear   (adv[k]),
                .d_tag   (in_tag[k]),
                .d_data  (in_data[k]),
                .q_valid (vld[k]),
                .q_tag   (tag_q[k]),
                .q_data  (data_q[k])
            );
        end
    endgenerate
endmodule

// File: tb/tb_exec_mult_unit.sv
// tb_exec_mult_unit: directed scenarios checked against an in-order queue model
module tb_exec_mult_unit;
    localparam int N = 4;

    logic        clk;
    logic        reset;
    logic [5:0]  issuemult_rdtag;
    logic [31:0] issuemult_rsdata;
    logic [31:0] issuemult_rtdata;
    logic        issuemult_ready;
    logic        issuemult_done;
    logic        multcdb_req;
    logic [5:0]  multcdb_tag;
    logic [31:0] multcdb_data;
    logic        multcdb_grant;

    exec_mult_unit #(.N_STAGES(N)) dut (
        .clk              (clk),
        .reset            (reset),
        .issuemult_rdtag  (issuemult_rdtag),
        .issuemult_rsdata (issuemult_rsdata),
        .issuemult_rtdata (issuemult_rtdata),
        .issuemult_ready  (issuemult_ready),
        .issuemult_done   (issuemult_done),
        .multcdb_req      (multcdb_req),
        .multcdb_tag      (multcdb_tag),
        .multcdb_data     (multcdb_data),
        .multcdb_grant    (multcdb_grant)
    );

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        int          arr;
    } item_t;

    typedef struct {
        logic [5:0]  tag;
        logic [31:0] data;
        int          cyc;
    } obs_t;

    item_t       q[$];
    obs_t        log_q[$];
    int          n_cmp = 0;
    int          n_err = 0;
    int          cyc = 0;
    logic        zero_flag = 1'b1;
    logic [63:0] banned = '0;

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s cycle %0d: got %0h expected %0h", name, cyc, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Model: results leave in issue order; an item reaches the output N cycles after
    // acceptance or one cycle after its predecessor leaves, whichever is later.
    // Acceptance is refused only when N items are held and none leaves this cycle.
    initial begin
        logic exp_req, exp_done;
        logic [31:0] p;
        forever begin
            @(negedge clk);
            exp_req  = (q.size() > 0) && (q[0].arr <= cyc);
            exp_done = issuemult_ready && !reset && !(q.size() == N && !(exp_req && multcdb_grant));
            check("done", {31'b0, issuemult_done}, {31'b0, exp_done});
            check("req", {31'b0, multcdb_req}, {31'b0, exp_req});
            if (exp_req) begin
                check("tag", {26'b0, multcdb_tag}, {26'b0, q[0].tag});
                check("data", multcdb_data, q[0].data);
                zero_flag = 1'b0;
            end else if (zero_flag) begin
                check("reset_tag", {26'b0, multcdb_tag}, 32'd0);
                check("reset_data", multcdb_data, 32'd0);
            end
            check("banned_tag", {31'b0, multcdb_req && banned[multcdb_tag]}, 32'd0);
            if (multcdb_req && multcdb_grant)
                log_q.push_back('{multcdb_tag, multcdb_data, cyc});
            @(posedge clk);
            if (reset) begin
                q.delete();
                zero_flag = 1'b1;
            end else begin
                if (exp_req && multcdb_grant) begin
                    void'(q.pop_front());
                    if (q.size() > 0 && q[0].arr < cyc + 1) q[0].arr = cyc + 1;
                end
                if (exp_done) begin
                    p = issuemult_rsdata * issuemult_rtdata;
                    q.push_back('{issuemult_rdtag, p, cyc + N});
                end
            end
            cyc++;
        end
    end

    initial begin
        int acc;
        int exp_d[4];
        logic [31:0] ea[3];
        logic [31:0] eb[3];
        logic [31:0] ep[3];
        reset = 1'b1;
        issuemult_ready = 1'b0;
        issuemult_rdtag = '0;
        issuemult_rsdata = '0;
        issuemult_rtdata = '0;
        multcdb_grant = 1'b0;
        repeat (3) tick();
        reset = 1'b0;
        multcdb_grant = 1'b1;
        tick();

        // single multiply
        issuemult_ready = 1'b1;
        issuemult_rdtag = 6'd7;
        issuemult_rsdata = 32'd3;
        issuemult_rtdata = 32'd5;
        @(negedge clk);
        check("s1_done", {31'b0, issuemult_done}, 32'd1);
        tick();
        issuemult_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            @(negedge clk);
            check("s1_req", {31'b0, multcdb_req}, (i == 4) ? 32'd1 : 32'd0);
            if (i == 4) begin
                check("s1_tag", {26'b0, multcdb_tag}, 32'd7);
                check("s1_data", multcdb_data, 32'd15);
            end
        end
        tick();

        // back-to-back
        log_q.delete();
        exp_d = '{6, 20, 42, 72};
        for (int i = 0; i < 4; i++) begin
            issuemult_ready = 1'b1;
            issuemult_rdtag = 6'(i + 1);
            issuemult_rsdata = 32'(2 * i + 2);
            issuemult_rtdata = 32'(2 * i + 3);
            tick();
        end
        issuemult_ready = 1'b0;
        repeat (8) tick();
        check("b2b_count", log_q.size(), 32'd4);
        for (int i = 0; i < 4 && i < log_q.size(); i++) begin
            check("b2b_tag", {26'b0, log_q[i].tag}, 32'(i + 1));
            check("b2b_data", log_q[i].data, 32'(exp_d[i]));
            check("b2b_consecutive", 32'(log_q[i].cyc - log_q[0].cyc), 32'(i));
        end

        // backpressure
        log_q.delete();
        multcdb_grant = 1'b0;
        acc = 0;
        for (int i = 0; i < 8; i++) begin
            issuemult_ready = 1'b1;
            issuemult_rdtag = 6'(10 + acc);
            issuemult_rsdata = 32'(acc + 2);
            issuemult_rtdata = 32'(acc + 3);
            @(negedge clk);
            if (i >= 4) begin
                check("bp_done_low", {31'b0, issuemult_done}, 32'd0);
                check("bp_hold_tag", {26'b0, multcdb_tag}, 32'd10);
                check("bp_hold_data", multcdb_data, 32'd6);
            end
            if (issuemult_done) acc++;
            tick();
        end
        check("bp_accepted", 32'(acc), 32'd4);
        multcdb_grant = 1'b1;
        issuemult_rdtag = 6'(10 + acc);
        issuemult_rsdata = 32'(acc + 2);
        issuemult_rtdata = 32'(acc + 3);
        @(negedge clk);
        check("bp_accept_on_drain", {31'b0, issuemult_done}, 32'd1);
        tick();
        issuemult_ready = 1'b0;
        repeat (10) tick();
        check("bp_drain_count", log_q.size(), 32'd5);
        for (int i = 0; i < 5 && i < log_q.size(); i++)
            check("bp_drain_order", {26'b0, log_q[i].tag}, 32'(10 + i));
        if (log_q.size() == 5) check("bp_last_data", log_q[4].data, 32'd42);

        // arithmetic edges
        log_q.delete();
        ea = '{32'hFFFFFFFF, 32'h00010000, 32'h80000000};
        eb = '{32'h00000002, 32'h00010000, 32'hFFFFFFFF};
        ep = '{32'hFFFFFFFE, 32'h00000000, 32'h80000000};
        for (int i = 0; i < 3; i++) begin
            issuemult_ready = 1'b1;
            issuemult_rdtag = 6'(20 + i);
            issuemult_rsdata = ea[i];
            issuemult_rtdata = eb[i];
            tick();
        end
        issuemult_ready = 1'b0;
        repeat (8) tick();
        check("edge_count", log_q.size(), 32'd3);
        for (int i = 0; i < 3 && i < log_q.size(); i++)
            check("edge_data", log_q[i].data, ep[i]);

        // reset mid-flight
        log_q.delete();
        banned[40] = 1'b1;
        banned[41] = 1'b1;
        banned[42] = 1'b1;
        banned[43] = 1'b1;
        for (int i = 0; i < 3; i++) begin
            issuemult_ready = 1'b1;
            issuemult_rdtag = 6'(40 + i);
            issuemult_rsdata = 32'(i + 1);
            issuemult_rtdata = 32'd9;
            tick();
        end
        reset = 1'b1;
        issuemult_rdtag = 6'd43;
        @(negedge clk);
        check("rst_done_low", {31'b0, issuemult_done}, 32'd0);
        tick();
        reset = 1'b0;
        issuemult_ready = 1'b0;
        @(negedge clk);
        check("rst_req_low", {31'b0, multcdb_req}, 32'd0);
        tick();
        repeat (10) tick();
        check("rst_nothing_out", log_q.size(), 32'd0);

        // idle with stray grant
        issuemult_ready = 1'b0;
        for (int i = 0; i < 10; i++) begin
            multcdb_grant = (i % 2) == 0;
            tick();
        end
        check("idle_nothing_out", log_q.size(), 32'd0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
